// File: rtl/lzd_dec_32b.sv
// ---------------------------------------------------------------------------
// lzd_dec_32b
//
// Inverse of the 32-bit leading-one detector. Takes a 5-bit bit position
// plus a "position is meaningful" flag. Rebuilds two 32-bit words from them:
// the one-hot word with only that bit set, and a thermometer mask covering
// that bit and every bit below it. When the flag is low, both words are zero
// and o_zero is set.
//
// The block is a two-stage valid/ready pipeline with full throughput:
//   s1 : decodes the low four position bits into a 16-bit one-hot and a
//        16-bit mask. It keeps the half select (position bit 4) and the
//        zero flag alongside.
//   s2 : places the 16-bit pieces into the upper or lower half of the
//        32-bit outputs.
// This 16/16 split follows the hierarchy of the detector.
//
// Ports
//   i_clk       sole clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_valid     upstream item present
//   o_ready     block accepts an item this cycle (combinational from i_ready)
//   i_po        bit position of the leading one, 0..31
//   i_po_valid  position meaningful; 0 means the source word was all zeros
//   o_valid     output item present
//   i_ready     downstream accepts this cycle
//   o_onehot    only bit i_po set, zero when !i_po_valid
//   o_mask      bits [i_po:0] set, zero when !i_po_valid
//   o_zero      registered copy of !i_po_valid
// ---------------------------------------------------------------------------
module lzd_dec_32b (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [4:0]  i_po,
   input  logic        i_po_valid,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_onehot,
   output logic [31:0] o_mask,
   output logic        o_zero
);

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic        s1_valid_q, s1_valid_d;
   logic        s2_valid_q, s2_valid_d;
   logic        s1_adv;
   logic        s2_adv;

   assign s2_adv  = !s2_valid_q || i_ready;
   assign s1_adv  = !s1_valid_q || s2_adv;
   assign o_ready = s1_adv;

   // ------------------------------------------------------------------
   // Stage 1: 4-to-16 decode of the low position bits
   // ------------------------------------------------------------------
   logic        s1_half_q, s1_half_d;
   logic [15:0] s1_dec_q,  s1_dec_d;
   logic [15:0] s1_mask_q, s1_mask_d;
   logic        s1_zero_q, s1_zero_d;

   logic [15:0] dec16;
   logic [15:0] mask16;

   always_comb begin
      dec16  = '0;
      mask16 = '0;
      for (int i = 0; i < 16; i++) begin
         dec16[i]  = i_po_valid && (i_po[3:0] == 4'(i));
         mask16[i] = i_po_valid && (4'(i) <= i_po[3:0]);
      end
   end

   // Data registers are only loaded when a real item is captured. On a
   // drain-only advance, they keep their previous contents, so the outputs
   // do not toggle for bubbles.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_half_d  = s1_half_q;
      s1_dec_d   = s1_dec_q;
      s1_mask_d  = s1_mask_q;
      s1_zero_d  = s1_zero_q;
      if (s1_adv) begin
         s1_valid_d = i_valid;
         if (i_valid) begin
            s1_half_d = i_po[4];
            s1_dec_d  = dec16;
            s1_mask_d = mask16;
            s1_zero_d = !i_po_valid;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_q <= 1'b0;
         s1_half_q  <= 1'b0;
         s1_dec_q   <= '0;
         s1_mask_q  <= '0;
         s1_zero_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_half_q  <= s1_half_d;
         s1_dec_q   <= s1_dec_d;
         s1_mask_q  <= s1_mask_d;
         s1_zero_q  <= s1_zero_d;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: assemble the 32-bit words
   // ------------------------------------------------------------------
   logic [31:0] s2_onehot_q, s2_onehot_d;
   logic [31:0] s2_mask_q,   s2_mask_d;
   logic        s2_zero_q,   s2_zero_d;

   logic [31:0] onehot32;
   logic [31:0] mask32;

   // An upper-half position must fill the whole lower half of the mask.
   // The zero flag still overrides this, because the 16-bit pieces are
   // already clear but the half select is a don't-care.
   always_comb begin
      onehot32 = '0;
      mask32   = '0;
      if (!s1_zero_q) begin
         if (s1_half_q) begin
            onehot32 = {s1_dec_q, 16'h0000};
            mask32   = {s1_mask_q, 16'hFFFF};
         end else begin
            onehot32 = {16'h0000, s1_dec_q};
            mask32   = {16'h0000, s1_mask_q};
         end
      end
   end

   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_onehot_d = s2_onehot_q;
      s2_mask_d   = s2_mask_q;
      s2_zero_d   = s2_zero_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_onehot_d = onehot32;
            s2_mask_d   = mask32;
            s2_zero_d   = s1_zero_q;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid_q  <= 1'b0;
         s2_onehot_q <= '0;
         s2_mask_q   <= '0;
         s2_zero_q   <= 1'b0;
      end else begin
         s2_valid_q  <= s2_valid_d;
         s2_onehot_q <= s2_onehot_d;
         s2_mask_q   <= s2_mask_d;
         s2_zero_q   <= s2_zero_d;
      end
   end

   assign o_valid  = s2_valid_q;
   assign o_onehot = s2_onehot_q;
   assign o_mask   = s2_mask_q;
   assign o_zero   = s2_zero_q;

endmodule

// File: tb/tb_lzd_dec_32b.sv
// ---------------------------------------------------------------------------
// tb_lzd_dec_32b
//
// Directed bench for lzd_dec_32b. Each cycle drives the inputs after the
// falling edge and checks the outputs shortly afterwards. Expected items ride
// in a two-slot occupancy model. For each item, the expected one-hot and mask
// are either hand-written constants or derived from the source word by
// smearing its MSB downwards.
// ---------------------------------------------------------------------------
module tb_lzd_dec_32b;

   logic        i_clk;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [4:0]  i_po;
   logic        i_po_valid;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_onehot;
   logic [31:0] o_mask;
   logic        o_zero;

   lzd_dec_32b dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_po       (i_po),
      .i_po_valid (i_po_valid),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_onehot   (o_onehot),
      .o_mask     (o_mask),
      .o_zero     (o_zero)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] oh;
      logic [31:0] mk;
      logic        z;
   } item_t;

   int    total;
   int    bad;
   int    n_in;
   int    n_out;
   item_t m1, m2;
   logic  m1v, m2v;
   logic  hold_v;
   logic [31:0] held_oh, held_mk;
   logic  held_z;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic item_t hand(input logic [31:0] x, input logic [31:0] oh,
                                  input logic [31:0] mk, input logic z);
      item_t it;
      it.x  = x;
      it.oh = oh;
      it.mk = mk;
      it.z  = z;
      return it;
   endfunction

   // Smearing the MSB downwards gives the thermometer mask directly.
   function automatic item_t from_word(input logic [31:0] x);
      logic [31:0] s;
      item_t it;
      s = x;
      s = s | (s >> 1);
      s = s | (s >> 2);
      s = s | (s >> 4);
      s = s | (s >> 8);
      s = s | (s >> 16);
      it.x  = x;
      it.mk = s;
      it.oh = s ^ (s >> 1);
      it.z  = (x == 32'd0);
      return it;
   endfunction

   function automatic logic [4:0] lod(input logic [31:0] x);
      logic [4:0] p;
      p = 5'd0;
      for (int i = 0; i < 32; i++)
         if (x[i]) p = 5'(i);
      return p;
   endfunction

   // One clock cycle: drive, check, clock, update model, return to negedge.
   task automatic step(input logic vin, input logic [4:0] po, input logic pov,
                       input item_t it, input logic rdy, output logic acc);
      logic s2a, s1a;
      i_valid    = vin;
      i_po       = po;
      i_po_valid = pov;
      i_ready    = rdy;
      #1;
      s2a = !m2v || rdy;
      s1a = !m1v || s2a;
      acc = vin && s1a;
      chk("o_ready", 32'(o_ready), 32'(s1a));
      chk("o_valid", 32'(o_valid), 32'(m2v));
      if (m2v) begin
         chk("onehot", o_onehot, m2.oh);
         chk("mask", o_mask, m2.mk);
         chk("zero", 32'(o_zero), 32'(m2.z));
         chk("popcount", 32'($countones(o_onehot)), o_zero ? 32'd0 : 32'd1);
         if (!o_zero) chk("mask_vs_onehot", o_mask, (o_onehot << 1) - 32'd1);
         if (m2.x != 32'd0) chk("x_outside_mask", m2.x & ~o_mask, 32'd0);
         if (rdy) n_out++;
      end
      if (hold_v) begin
         chk("hold_onehot", o_onehot, held_oh);
         chk("hold_mask", o_mask, held_mk);
         chk("hold_zero", 32'(o_zero), 32'(held_z));
      end
      hold_v  = m2v && !rdy;
      held_oh = o_onehot;
      held_mk = o_mask;
      held_z  = o_zero;
      @(posedge i_clk);
      if (s2a) begin
         m2v = m1v;
         m2  = m1;
      end
      if (s1a) begin
         m1v = vin;
         m1  = it;
         if (vin) n_in++;
      end
      @(negedge i_clk);
   endtask

   initial begin
      logic        acc;
      logic [31:0] x;
      item_t       nil;
      nil    = '0;
      total  = 0;
      bad    = 0;
      n_in   = 0;
      n_out  = 0;
      m1     = '0;
      m2     = '0;
      m1v    = 1'b0;
      m2v    = 1'b0;
      hold_v = 1'b0;
      held_oh = '0;
      held_mk = '0;
      held_z  = 1'b0;

      i_rst      = 1'b1;
      i_valid    = 1'b0;
      i_po       = 5'd0;
      i_po_valid = 1'b0;
      i_ready    = 1'b1;
      #3;
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_ready", 32'(o_ready), 32'd1);
      chk("rst_onehot", o_onehot, 32'd0);
      chk("rst_mask", o_mask, 32'd0);
      chk("rst_zero", 32'(o_zero), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Single item at position 0, two-edge latency.
      step(1'b1, 5'd0, 1'b1, hand(32'h1, 32'h0000_0001, 32'h0000_0001, 1'b0), 1'b1, acc);
      step(1'b0, 5'd0, 1'b0, nil, 1'b1, acc);
      chk("latency_valid", 32'(o_valid), 32'd1);
      step(1'b0, 5'd0, 1'b0, nil, 1'b1, acc);
      step(1'b0, 5'd0, 1'b0, nil, 1'b1, acc);

      // Half-boundary positions, back to back.
      step(1'b1, 5'd15, 1'b1, hand(32'h0000_8000, 32'h0000_8000, 32'h0000_FFFF, 1'b0), 1'b1, acc);
      step(1'b1, 5'd16, 1'b1, hand(32'h0001_0000, 32'h0001_0000, 32'h0001_FFFF, 1'b0), 1'b1, acc);
      step(1'b1, 5'd31, 1'b1, hand(32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0), 1'b1, acc);
      for (int k = 0; k < 4; k++) step(1'b0, 5'd0, 1'b0, nil, 1'b1, acc);

      // Zero input: the position is ignored.
      step(1'b1, 5'd31, 1'b0, hand(32'h0, 32'h0, 32'h0, 1'b1), 1'b1, acc);
      for (int k = 0; k < 3; k++) step(1'b0, 5'd0, 1'b0, nil, 1'b1, acc);

      // Stream 0..31 under random backpressure.
      for (int p = 0; p < 32; p++) begin
         x = 32'd1 << p;
         acc = 1'b0;
         for (int t = 0; t < 40 && !acc; t++)
            step(1'b1, 5'(p), 1'b1, from_word(x), 1'($urandom_range(0, 1)), acc);
         chk("stream_accept", 32'(acc), 32'd1);
      end
      for (int k = 0; k < 20; k++) step(1'b0, 5'd0, 1'b0, nil, 1'($urandom_range(0, 1)), acc);
      for (int k = 0; k < 3; k++) step(1'b0, 5'd0, 1'b0, nil, 1'b1, acc);

      // Round trip from a detector model: every one-hot word, zero, random words.
      for (int k = 0; k < 32; k++) begin
         x = 32'd1 << k;
         step(1'b1, lod(x), 1'b1, from_word(x), 1'b1, acc);
      end
      x = 32'd0;
      step(1'b1, 5'd7, 1'b0, from_word(x), 1'b1, acc);
      for (int k = 0; k < 1000; k++) begin
         x = $urandom;
         step(1'b1, lod(x), x != 32'd0, from_word(x), 1'b1, acc);
      end
      for (int k = 0; k < 3; k++) step(1'b0, 5'd0, 1'b0, nil, 1'b1, acc);

      // Fill both stages, then reset mid-stream.
      step(1'b1, 5'd3, 1'b1, from_word(32'h8), 1'b0, acc);
      step(1'b1, 5'd20, 1'b1, from_word(32'h0010_0000), 1'b0, acc);
      step(1'b1, 5'd9, 1'b1, from_word(32'h200), 1'b0, acc);
      chk("full_o_ready", 32'(o_ready), 32'd0);
      i_valid = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      chk("midrst_o_valid", 32'(o_valid), 32'd0);
      chk("midrst_o_ready", 32'(o_ready), 32'd1);
      chk("midrst_onehot", o_onehot, 32'd0);
      n_in   = n_in - int'(m1v) - int'(m2v);
      m1v    = 1'b0;
      m2v    = 1'b0;
      hold_v = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int k = 0; k < 4; k++) step(1'b0, 5'd0, 1'b0, nil, 1'b1, acc);
      step(1'b1, 5'd12, 1'b1, hand(32'h1000, 32'h0000_1000, 32'h0000_1FFF, 1'b0), 1'b1, acc);
      for (int k = 0; k < 3; k++) step(1'b0, 5'd0, 1'b0, nil, 1'b1, acc);

      chk("items_in_vs_out", 32'(n_out), 32'(n_in));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
